// File: rtl/ex_mem_branch_stage_pkg.sv
// Shared branch condition codes and stage state encodings for the EX/MEM branch stage.
// Optional statistics counters in the top are enabled by defining BRANCH_STATS_EN.
package ex_mem_branch_stage_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_e;

    // JALR targets always land on a halfword boundary.
    function automatic logic [31:0] clear_lsb(input logic [31:0] addr);
        clear_lsb = {addr[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/ex_mem_branch_stage_branch_cond.sv
// Combinational branch condition evaluation from the ALU flags of a SUB (rs1 - rs2).
module branch_cond
    import ex_mem_branch_stage_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       z,
    input  logic       s,
    input  logic       c,
    input  logic       v,
    input  logic       op_b_zero,
    output logic       cond
);

    // Unsigned compares treat a zero operand B as "no borrow" regardless of the carry.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            BR_BEQ:  cond = z;
            BR_BNE:  cond = ~z;
            BR_BLT:  cond = s ^ v;
            BR_BGE:  cond = ~(s ^ v);
            BR_BLTU: cond = ~c & ~op_b_zero;
            BR_BGEU: cond = c | op_b_zero;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_branch_stage.sv
// EX/MEM pipeline register with branch/jump resolution, PC redirect and one-slot squash.
// Define BRANCH_STATS_EN to add the br_count / br_taken_count statistics outputs.
module ex_mem_branch_stage
    import ex_mem_branch_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  ex_valid,
    input  logic [XLEN-1:0]       alu_result,
    input  logic                  zFlag,
    input  logic                  sFlag,
    input  logic                  cFlag,
    input  logic                  vFlag,
    input  logic                  op_b_zero,
    input  logic                  is_branch,
    input  logic                  is_jal,
    input  logic                  is_jalr,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       pc,
    input  logic [XLEN-1:0]       imm,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  reg_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic                  mem_valid,
    output logic [XLEN-1:0]       mem_alu_result,
    output logic [XLEN-1:0]       mem_rs2_data,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_reg_write,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  redirect,
    output logic [XLEN-1:0]       redirect_pc,
    output logic                  flush_if_id,
    output logic                  flush_id_ex
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]           br_count,
    output logic [31:0]           br_taken_count
`endif
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

    state_e          state_r;
    state_e          state_nxt_s;
    logic            cond_s;
    logic            take_s;
    logic            squash_s;
    logic            fire_s;
    logic            keep_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] result_s;

    branch_cond u_branch_cond (
        .funct3    (funct3),
        .z         (zFlag),
        .s         (sFlag),
        .c         (cFlag),
        .v         (vFlag),
        .op_b_zero (op_b_zero),
        .cond      (cond_s)
    );

    assign take_s   = ex_valid & (is_jal | is_jalr | (is_branch & cond_s));
    assign squash_s = (state_r == ST_SQUASH);
    assign fire_s   = ~stall & ~squash_s & take_s;
    assign keep_s   = ex_valid & ~squash_s;

    // Redirect target and MEM-bound result (link address for jumps).
    always_comb begin
        target_s = pc + imm;
        result_s = alu_result;
        if (is_jalr) begin
            target_s = XLEN'(clear_lsb(32'(alu_result)));
        end else begin
            target_s = pc + imm;
        end
        if (is_jal | is_jalr) begin
            result_s = pc + PC_STEP;
        end else begin
            result_s = alu_result;
        end
    end

    // Next-state logic: one squash slot after every taken control transfer.
    always_comb begin
        state_nxt_s = state_r;
        if (stall) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                ST_RUN:    state_nxt_s = take_s ? ST_SQUASH : ST_RUN;
                ST_SQUASH: state_nxt_s = ST_RUN;
                default:   state_nxt_s = ST_RUN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // EX/MEM pipeline register and redirect/flush outputs; everything holds on stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid      <= 1'b0;
            mem_alu_result <= '0;
            mem_rs2_data   <= '0;
            mem_rd         <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            redirect       <= 1'b0;
            redirect_pc    <= '0;
            flush_if_id    <= 1'b0;
            flush_id_ex    <= 1'b0;
        end else if (!stall) begin
            mem_valid      <= keep_s;
            mem_alu_result <= result_s;
            mem_rs2_data   <= rs2_data;
            mem_rd         <= rd;
            mem_reg_write  <= keep_s & reg_write;
            mem_mem_read   <= keep_s & mem_read;
            mem_mem_write  <= keep_s & mem_write;
            redirect       <= fire_s;
            flush_if_id    <= fire_s;
            flush_id_ex    <= fire_s;
            if (fire_s) begin
                redirect_pc <= target_s;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // Branch statistics: only real (non-squashed, non-stalled) branches are counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_count       <= 32'd0;
            br_taken_count <= 32'd0;
        end else if (!stall && !squash_s && ex_valid && is_branch) begin
            br_count <= br_count + 32'd1;
            if (cond_s) begin
                br_taken_count <= br_taken_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// Directed scoreboard bench for ex_mem_branch_stage (define BRANCH_STATS_EN to check counters).
module tb_ex_mem_branch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic [31:0] alu_result;
    logic        zFlag, sFlag, cFlag, vFlag, op_b_zero;
    logic        is_branch, is_jal, is_jalr;
    logic [2:0]  funct3;
    logic [31:0] pc, imm, rs2_data;
    logic [4:0]  rd;
    logic        reg_write, mem_read, mem_write;
    logic        mem_valid;
    logic [31:0] mem_alu_result, mem_rs2_data;
    logic [4:0]  mem_rd;
    logic        mem_reg_write, mem_mem_read, mem_mem_write;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_if_id, flush_id_ex;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_count, br_taken_count;
`endif

    typedef struct packed {
        logic        valid;
        logic        chk_data;
        logic [31:0] res;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] nbr;
        logic [31:0] ntk;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ex_mem_branch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .ex_valid       (ex_valid),
        .alu_result     (alu_result),
        .zFlag          (zFlag),
        .sFlag          (sFlag),
        .cFlag          (cFlag),
        .vFlag          (vFlag),
        .op_b_zero      (op_b_zero),
        .is_branch      (is_branch),
        .is_jal         (is_jal),
        .is_jalr        (is_jalr),
        .funct3         (funct3),
        .pc             (pc),
        .imm            (imm),
        .rs2_data       (rs2_data),
        .rd             (rd),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_valid      (mem_valid),
        .mem_alu_result (mem_alu_result),
        .mem_rs2_data   (mem_rs2_data),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex)
`ifdef BRANCH_STATS_EN
        ,
        .br_count       (br_count),
        .br_taken_count (br_taken_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
        chk({tag, "_alu_result"}, mem_alu_result, 32'd0);
        chk({tag, "_rs2"}, mem_rs2_data, 32'd0);
        chk({tag, "_rd"}, 32'(mem_rd), 32'd0);
        chk({tag, "_ctrl"}, 32'({mem_reg_write, mem_mem_read, mem_mem_write}), 32'd0);
        chk({tag, "_redirect"}, 32'(redirect), 32'd0);
        chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
        chk({tag, "_flushes"}, 32'({flush_if_id, flush_id_ex}), 32'd0);
`ifdef BRANCH_STATS_EN
        chk({tag, "_br_count"}, br_count, 32'd0);
        chk({tag, "_br_taken"}, br_taken_count, 32'd0);
`endif
    endtask

    task automatic check_out();
        exp_t e;
        n_vec++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("mem_valid", 32'(mem_valid), 32'(e.valid));
            chk("mem_reg_write", 32'(mem_reg_write), 32'(e.rw));
            chk("mem_mem_read", 32'(mem_mem_read), 32'(e.mr));
            chk("mem_mem_write", 32'(mem_mem_write), 32'(e.mw));
            chk("redirect", 32'(redirect), 32'(e.redir));
            chk("flush_if_id", 32'(flush_if_id), 32'(e.redir));
            chk("flush_id_ex", 32'(flush_id_ex), 32'(e.redir));
            chk("redirect_pc", redirect_pc, e.rpc);
            if (e.chk_data) begin
                chk("mem_alu_result", mem_alu_result, e.res);
                chk("mem_rs2_data", mem_rs2_data, e.rs2);
                chk("mem_rd", 32'(mem_rd), 32'(e.rd));
            end
`ifdef BRANCH_STATS_EN
            chk("br_count", br_count, e.nbr);
            chk("br_taken_count", br_taken_count, e.ntk);
`endif
        end
    endtask

    // cls = {is_branch, is_jal, is_jalr}; fl = {z, s, c, v, op_b_zero}.
    task automatic step(input logic st, input logic v, input logic [2:0] cls, input logic [2:0] f3,
                        input logic [4:0] fl, input logic [31:0] p, input logic [31:0] im,
                        input logic [31:0] a, input logic e_valid, input logic [31:0] e_res,
                        input logic e_redir, input logic [31:0] e_rpc);
        exp_t e;
        stall      = st;
        ex_valid   = v;
        {is_branch, is_jal, is_jalr} = cls;
        funct3     = f3;
        {zFlag, sFlag, cFlag, vFlag, op_b_zero} = fl;
        pc         = p;
        imm        = im;
        alu_result = a;
        rs2_data   = a ^ 32'hA5A5_0000;
        rd         = p[6:2];
        reg_write  = 1'b1;
        mem_read   = a[0];
        mem_write  = a[1];
        if (st) begin
            e = last_exp;
        end else begin
            e.valid    = e_valid;
            e.chk_data = e_valid;
            e.res      = e_res;
            e.rs2      = rs2_data;
            e.rd       = rd;
            e.rw       = e_valid;
            e.mr       = e_valid & a[0];
            e.mw       = e_valid & a[1];
            e.redir    = e_redir;
            e.rpc      = e_rpc;
            e.nbr      = last_exp.nbr;
            e.ntk      = last_exp.ntk;
            if (!last_exp.redir && v && cls[2]) begin
                e.nbr = e.nbr + 32'd1;
                if (e_redir) e.ntk = e.ntk + 32'd1;
            end
        end
        sb.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        last_exp = '0;
        rst = 1'b0;
        step_inputs_idle();
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // st v cls f3 flags pc imm alu | valid result redirect redirect_pc
        step(1'b0, 1'b1, 3'b100, 3'b000, 5'b10000, 32'h100, 32'h20, 32'h0,  1'b1, 32'h0, 1'b1, 32'h120);
        step(1'b0, 1'b1, 3'b010, 3'b000, 5'b00000, 32'h200, 32'h8,  32'h55, 1'b0, 32'h0, 1'b0, 32'h120);
        step(1'b0, 1'b1, 3'b100, 3'b110, 5'b00001, 32'h300, 32'h10, 32'h7,  1'b1, 32'h7, 1'b0, 32'h120);
        step(1'b0, 1'b1, 3'b100, 3'b100, 5'b01010, 32'h340, 32'h10, 32'h4,  1'b1, 32'h4, 1'b0, 32'h120);
        step(1'b0, 1'b1, 3'b100, 3'b111, 5'b00001, 32'h400, 32'hFFFF_FFF0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h3F0);
        step(1'b0, 1'b1, 3'b100, 3'b000, 5'b10000, 32'h800, 32'h4,  32'h0,  1'b0, 32'h0, 1'b0, 32'h3F0);
        step(1'b0, 1'b1, 3'b100, 3'b001, 5'b10000, 32'h500, 32'h40, 32'h0,  1'b1, 32'h0, 1'b0, 32'h3F0);
        step(1'b0, 1'b1, 3'b001, 3'b000, 5'b00000, 32'h40,  32'h0,  32'h2003, 1'b1, 32'h44, 1'b1, 32'h2002);
        step(1'b0, 1'b0, 3'b000, 3'b000, 5'b00000, 32'h44,  32'h0,  32'h0,  1'b0, 32'h0, 1'b0, 32'h2002);
        step(1'b0, 1'b1, 3'b010, 3'b000, 5'b00000, 32'hFFFF_FFF0, 32'h20, 32'h1234, 1'b1, 32'hFFFF_FFF4, 1'b1, 32'h10);
        step(1'b0, 1'b0, 3'b000, 3'b000, 5'b00000, 32'h14,  32'h0,  32'h0,  1'b0, 32'h0, 1'b0, 32'h10);
        step(1'b0, 1'b1, 3'b100, 3'b010, 5'b11111, 32'h900, 32'h40, 32'h3,  1'b1, 32'h3, 1'b0, 32'h10);
        step(1'b0, 1'b0, 3'b010, 3'b000, 5'b00000, 32'h904, 32'h40, 32'h0,  1'b0, 32'h0, 1'b0, 32'h10);

        // Taken branch held by stall: outputs frozen, redirect follows release.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 3'b100, 3'b000, 5'b10000, 32'h600, 32'h4, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        step(1'b0, 1'b1, 3'b100, 3'b000, 5'b10000, 32'h600, 32'h4, 32'h0, 1'b1, 32'h0, 1'b1, 32'h604);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 3'b000, 3'b000, 5'b00000, 32'h604, 32'h0, 32'h9, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        step(1'b0, 1'b1, 3'b000, 3'b000, 5'b00000, 32'h604, 32'h0, 32'h9, 1'b0, 32'h0, 1'b0, 32'h604);

        // Reset asserted while squashing.
        step(1'b0, 1'b1, 3'b100, 3'b000, 5'b10000, 32'h700, 32'h8, 32'h0, 1'b1, 32'h0, 1'b1, 32'h708);
        ex_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk_all_zero("async_reset");
        last_exp = '0;
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 3'b010, 3'b000, 5'b00000, 32'h70C, 32'h8, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 3'b010, 3'b000, 5'b00000, 32'h710, 32'h8, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    task automatic step_inputs_idle();
        stall = 1'b0; ex_valid = 1'b0; alu_result = 32'h0;
        {zFlag, sFlag, cFlag, vFlag, op_b_zero} = 5'b00000;
        {is_branch, is_jal, is_jalr} = 3'b000;
        funct3 = 3'b000; pc = 32'h0; imm = 32'h0; rs2_data = 32'h0; rd = 5'd0;
        reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

endmodule
